note_playback_scheduler: RTL and testbench
==========================================

Name: note_playback_scheduler

Overview:
Read-side counterpart to the note recorder. It repeatedly scans NoteStorage during playback and compares each stored note's start/end timestamps against the live microsecond counter. It drives a registered 24-bit mask of notes currently sounding, which feeds the tone generator and the keyboard highlight overlay. It also detects end of song.

Parameters:
DEPTH, 101, number of NoteStorage records scanned; addresses 0..DEPTH-1.
ADDR_W, 7, width of the read address.
TIME_W, 29, timestamp width in microseconds.
NOTE_W, 5, note index field width.
NUM_NOTES, 24, number of playable notes; width of the active mask.

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
playStart  input  1  single-cycle pulse that starts or restarts playback
playStop  input  1  single-cycle pulse that stops playback
currentTime  input  TIME_W  microsecond counter value
readAddress  output  ADDR_W  NoteStorage read address
readData  input  NOTE_W+2*TIME_W  record at readAddress, registered, 1-cycle latency
activeNotes  output  NUM_NOTES  one bit per note currently sounding
playing  output  1  high while a scan loop is running
scanDone  output  1  single-cycle pulse when activeNotes is updated
songEnd  output  1  sticky; set when every scanned note has finished
timerReset  output  1  single-cycle pulse that requests a timeCounter reset

Behaviour:
- Record layout: [NOTE_W+2*TIME_W-1 : 2*TIME_W] is note index; [2*TIME_W-1 : TIME_W] is startTime; [TIME_W-1 : 0] is endTime.
- An all-zero record is empty and terminates the scan.
- A record with endTime==0 is open (still held).
- Reset (resetn==0 at clk edge): all outputs 0, readAddress 0, shadow mask 0, FSM in IDLE.
- States:
  - IDLE
  - SCAN: issue an address every cycle.
  - DRAIN: consume the last in-flight read.
  - COMMIT
- IDLE -> SCAN on playStart:
  - readAddress<=0; shadow<=0; songEnd<=0; playing<=1; timerReset pulses 1 cycle.
  - Time snapshot: the currentTime value is latched at the first SCAN cycle and used for the whole scan, giving a consistent frame.
- SCAN pipeline:
  - Each cycle, readAddress increments.
  - A valid flag is delayed 1 cycle to qualify readData.
  - A qualified record is active iff startTime <= snapTime AND (endTime==0 OR snapTime < endTime). If active, shadow[note]<=1.
  - A note index >= NUM_NOTES is ignored (no mask bit, no error).
  - A qualified record that is not open and has snapTime < endTime sets the pending flag "notFinished"; open records set it too.
- SCAN -> DRAIN when readAddress==DEPTH-1 is issued.
  - A qualified empty record ends the scan immediately; later addresses are discarded.
- DRAIN -> COMMIT after the last qualified record is processed.
- COMMIT:
  - activeNotes<=shadow; scanDone pulses; shadow cleared; readAddress<=0.
  - If notFinished==0: songEnd<=1, playing<=0, go to IDLE. activeNotes is cleared the next cycle.
  - Otherwise return to SCAN.
- Scan latency is at most DEPTH+3 cycles. activeNotes changes only in COMMIT.
- playStop in any state: next cycle go to IDLE with activeNotes<=0 and playing<=0. songEnd is unchanged.
- Simultaneous playStart and playStop: playStart wins and restarts from address 0.
- playStart while in SCAN, DRAIN or COMMIT: restart (shadow cleared, timerReset pulsed).
- Comparisons are unsigned TIME_W-bit; no wrap handling. Counter overflow is out of scope.
- An empty memory (record 0 all zeros) gives COMMIT with mask 0 and songEnd=1 in 4 cycles.

Optional Feature:
LOOP_PLAYBACK_EN
- Defined: on song end, COMMIT pulses timerReset, keeps playing=1, leaves songEnd=0 and returns to SCAN from address 0 with a fresh snapshot. The song loops until playStop.
- Undefined: song end behaves as above (songEnd=1, go to IDLE). timerReset pulses only on playStart.

Test Plan:
- Reset with resetn=0 for 2 cycles while playStart=1 -> all outputs 0, readAddress 0, FSM IDLE on release.
- Memory holds {note 3, start 100, end 500} at addr 0, empty at addr 1; currentTime held at 200; pulse playStart -> scanDone within 5 cycles, activeNotes=24'h000008.
- Same memory with currentTime stepped 50, 300, 600 -> activeNotes 0, then bit3, then 0 with songEnd=1 and playing=0.
- Record {note 23, start 10, end 0} (open) with time 20, plus {note 30, start 0, end 99} -> activeNotes bit23 set, note 30 ignored, songEnd stays 0.
- Full 101-record memory, all active at time 5 for notes 0..23 -> single COMMIT after DEPTH+3 cycles with activeNotes=24'hFFFFFF. Inject playStop mid-scan -> activeNotes=0 the next cycle.
- LOOP_PLAYBACK_EN defined, single note ending at 100, time 150 -> timerReset pulse at COMMIT, playing stays 1, songEnd 0. Undefined -> songEnd=1.

Source files
------------

// File: rtl/note_playback_scheduler_if.sv
// NoteStorage read port. The scheduler drives the address and the storage
// returns the registered record one cycle later.
interface note_playback_scheduler_if #(
    parameter int ADDR_W = 7,
    parameter int REC_W  = 63
);
    logic [ADDR_W-1:0] readAddress;
    logic [REC_W-1:0]  readData;

    modport master (output readAddress, input readData);
    modport slave  (input readAddress, output readData);
endinterface

// File: rtl/note_playback_scheduler.sv
// Scans NoteStorage against a per-scan time snapshot and publishes the sounding-note mask.
// Optional looping playback is enabled with the LOOP_PLAYBACK_EN macro.
module note_playback_scheduler #(
    parameter int DEPTH     = 101,
    parameter int ADDR_W    = 7,
    parameter int TIME_W    = 29,
    parameter int NOTE_W    = 5,
    parameter int NUM_NOTES = 24
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     playStart,
    input  logic                     playStop,
    input  logic [TIME_W-1:0]        currentTime,
    note_playback_scheduler_if.master mem,
    output logic [NUM_NOTES-1:0]     activeNotes,
    output logic                     playing,
    output logic                     scanDone,
    output logic                     songEnd,
    output logic                     timerReset
);
    localparam int REC_W = NOTE_W + 2*TIME_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, COMMIT} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [NUM_NOTES-1:0]  shadow_q, shadow_d;
    logic [NUM_NOTES-1:0]  active_q, active_d;
    logic [TIME_W-1:0]     snap_q, snap_d;
    logic                  valid_q, valid_d;
    logic                  first_q, first_d;
    logic                  pending_q, pending_d;
    logic                  playing_q, playing_d;
    logic                  done_q, done_d;
    logic                  song_end_q, song_end_d;
    logic                  timer_rst_q, timer_rst_d;

    logic [NOTE_W-1:0]     rec_note;
    logic [TIME_W-1:0]     rec_start;
    logic [TIME_W-1:0]     rec_end;
    logic                  rec_empty;
    logic                  rec_unfinished;
    logic                  rec_active;

    assign rec_note       = mem.readData[REC_W-1 -: NOTE_W];
    assign rec_start      = mem.readData[2*TIME_W-1 -: TIME_W];
    assign rec_end        = mem.readData[TIME_W-1:0];
    assign rec_empty      = (mem.readData == '0);
    assign rec_unfinished = (rec_end == '0) || (snap_q < rec_end);
    assign rec_active     = (rec_start <= snap_q) && rec_unfinished;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        snap_d      = snap_q;
        valid_d     = 1'b0;
        first_d     = 1'b0;
        pending_d   = pending_q;
        playing_d   = playing_q;
        done_d      = 1'b0;
        song_end_d  = song_end_q;
        timer_rst_d = 1'b0;

        if (playStart) begin
            state_d     = SCAN;
            addr_d      = '0;
            shadow_d    = '0;
            song_end_d  = 1'b0;
            playing_d   = 1'b1;
            timer_rst_d = 1'b1;
            first_d     = 1'b1;
            pending_d   = 1'b0;
        end else if (playStop) begin
            state_d   = IDLE;
            active_d  = '0;
            playing_d = 1'b0;
        end else begin
            // Records arriving in SCAN or DRAIN belong to the current frame.
            if ((state_q == SCAN || state_q == DRAIN) && valid_q && !rec_empty) begin
                if (rec_active && (32'(rec_note) < NUM_NOTES))
                    shadow_d[rec_note] = 1'b1;
                if (rec_unfinished)
                    pending_d = 1'b1;
            end

            case (state_q)
                IDLE: active_d = '0;
                SCAN: begin
                    if (first_q)
                        snap_d = currentTime;
                    if (valid_q && rec_empty) begin
                        state_d = COMMIT;
                    end else begin
                        valid_d = 1'b1;
                        if (addr_q == LAST_ADDR)
                            state_d = DRAIN;
                        else
                            addr_d = addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: state_d = COMMIT;
                COMMIT: begin
                    active_d  = shadow_q;
                    done_d    = 1'b1;
                    shadow_d  = '0;
                    addr_d    = '0;
                    pending_d = 1'b0;
                    if (pending_q) begin
                        state_d = SCAN;
                        first_d = 1'b1;
                    end else begin
`ifdef LOOP_PLAYBACK_EN
                        state_d     = SCAN;
                        first_d     = 1'b1;
                        timer_rst_d = 1'b1;
`else
                        state_d    = IDLE;
                        song_end_d = 1'b1;
                        playing_d  = 1'b0;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            snap_q      <= '0;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            pending_q   <= 1'b0;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
            song_end_q  <= 1'b0;
            timer_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            snap_q      <= snap_d;
            valid_q     <= valid_d;
            first_q     <= first_d;
            pending_q   <= pending_d;
            playing_q   <= playing_d;
            done_q      <= done_d;
            song_end_q  <= song_end_d;
            timer_rst_q <= timer_rst_d;
        end
    end

    assign mem.readAddress = addr_q;
    assign activeNotes     = active_q;
    assign playing         = playing_q;
    assign scanDone        = done_q;
    assign songEnd         = song_end_q;
    assign timerReset      = timer_rst_q;
endmodule

// File: tb/tb_note_playback_scheduler.sv
// Directed bench for note_playback_scheduler with a frame-level reference model
// that predicts every output cycle by cycle from the stored song and the time input.
module tb_note_playback_scheduler;
    localparam int DEPTH     = 101;
    localparam int ADDR_W    = 7;
    localparam int TIME_W    = 29;
    localparam int NOTE_W    = 5;
    localparam int NUM_NOTES = 24;
    localparam int REC_W     = NOTE_W + 2*TIME_W;

    logic                 clk;
    logic                 resetn;
    logic                 playStart;
    logic                 playStop;
    logic [TIME_W-1:0]    currentTime;
    logic [NUM_NOTES-1:0] activeNotes;
    logic                 playing;
    logic                 scanDone;
    logic                 songEnd;
    logic                 timerReset;

    note_playback_scheduler_if #(.ADDR_W(ADDR_W), .REC_W(REC_W)) bus ();

    note_playback_scheduler dut (
        .clk(clk),
        .resetn(resetn),
        .playStart(playStart),
        .playStop(playStop),
        .currentTime(currentTime),
        .mem(bus),
        .activeNotes(activeNotes),
        .playing(playing),
        .scanDone(scanDone),
        .songEnd(songEnd),
        .timerReset(timerReset)
    );

    int total = 0;
    int bad   = 0;
    bit checkEn = 0;

    logic [REC_W-1:0] mem [0:127];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // NoteStorage stand-in with one cycle of registered read latency.
    always @(posedge clk) bus.readData <= mem[bus.readAddress];

    function automatic logic [REC_W-1:0] rec(input int note, input int st, input int en);
        return {NOTE_W'(note), TIME_W'(st), TIME_W'(en)};
    endfunction

    // Cycles from the start edge to the commit edge: one cycle per record read up to
    // and including the terminating empty record, plus pipeline and commit overhead.
    function automatic int scanLatency();
        int lat;
        bit found;
        lat = DEPTH + 2;
        found = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && mem[i] == '0) begin
                lat = i + 3;
                found = 1;
            end
        end
        return lat;
    endfunction

    function automatic void scanResult(input logic [TIME_W-1:0] t,
                                       output logic [NUM_NOTES-1:0] m, output bit nf);
        bit stop;
        int note;
        logic [TIME_W-1:0] st, en;
        m = '0;
        nf = 0;
        stop = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i] == '0) stop = 1;
            if (!stop) begin
                note = int'(mem[i][REC_W-1 -: NOTE_W]);
                st   = mem[i][2*TIME_W-1 -: TIME_W];
                en   = mem[i][TIME_W-1:0];
                if (en == 0 || t < en) begin
                    nf = 1;
                    if (st <= t && note < NUM_NOTES) m[note] = 1'b1;
                end
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model, advanced on each active edge from the inputs the DUT sampled.
    int                   cyc = 0;
    bit                   mRun = 0;
    int                   scanBegin = 0;
    int                   commitAt = 0;
    logic [TIME_W-1:0]    mSnap = '0;
    logic [NUM_NOTES-1:0] mMask;
    bit                   mNf;
    logic [NUM_NOTES-1:0] expActive = '0;
    bit                   expPlaying = 0, expSongEnd = 0, expDone = 0, expTimer = 0;

    always @(posedge clk) begin
        cyc++;
        expDone  = 0;
        expTimer = 0;
        if (!resetn) begin
            mRun = 0;
            expActive = '0;
            expPlaying = 0;
            expSongEnd = 0;
        end else if (playStart) begin
            mRun = 1;
            expPlaying = 1;
            expSongEnd = 0;
            expTimer = 1;
            scanBegin = cyc;
            commitAt = cyc + scanLatency();
        end else if (playStop) begin
            mRun = 0;
            expActive = '0;
            expPlaying = 0;
        end else if (mRun) begin
            if (cyc == scanBegin + 1) mSnap = currentTime;
            if (cyc == commitAt) begin
                scanResult(mSnap, mMask, mNf);
                expActive = mMask;
                expDone = 1;
                if (mNf) begin
                    scanBegin = cyc;
                    commitAt = cyc + scanLatency();
                end else begin
`ifdef LOOP_PLAYBACK_EN
                    expTimer = 1;
                    scanBegin = cyc;
                    commitAt = cyc + scanLatency();
`else
                    expSongEnd = 1;
                    expPlaying = 0;
                    mRun = 0;
`endif
                end
            end
        end else begin
            expActive = '0;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model activeNotes", 32'(activeNotes), 32'(expActive));
            checkOutput("model playing", 32'(playing), 32'(expPlaying));
            checkOutput("model songEnd", 32'(songEnd), 32'(expSongEnd));
            checkOutput("model scanDone", 32'(scanDone), 32'(expDone));
            checkOutput("model timerReset", 32'(timerReset), 32'(expTimer));
        end
    end

    task automatic applyStimulus(input bit ps, input bit stop);
        playStart = ps;
        playStop  = stop;
        @(negedge clk);
        playStart = 1'b0;
        playStop  = 1'b0;
    endtask

    task automatic startAndWait(input bit withStop, input int maxCyc, output int n);
        playStart = 1'b1;
        playStop  = withStop;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            playStart = 1'b0;
            playStop  = 1'b0;
        end while (!scanDone && n < maxCyc);
        if (!scanDone) checkOutput("start scanDone timeout", 32'(scanDone), 32'd1);
    endtask

    task automatic waitScanDone(input int maxCyc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!scanDone && n < maxCyc);
        if (!scanDone) checkOutput("scanDone timeout", 32'(scanDone), 32'd1);
    endtask

    task automatic clearMem();
        for (int i = 0; i < 128; i++) mem[i] = '0;
    endtask

    initial begin
        #2000000;
        checkOutput("watchdog", 32'(checkEn), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        clearMem();
        resetn = 1'b0;
        playStart = 1'b1;
        playStop = 1'b0;
        currentTime = '0;

        // Reset wins over a held playStart.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset activeNotes", 32'(activeNotes), 32'd0);
        checkOutput("reset readAddress", 32'(bus.readAddress), 32'd0);
        checkOutput("reset playing", 32'(playing), 32'd0);
        checkOutput("reset scanDone", 32'(scanDone), 32'd0);
        checkOutput("reset songEnd", 32'(songEnd), 32'd0);
        checkOutput("reset timerReset", 32'(timerReset), 32'd0);
        checkEn = 1;
        resetn = 1'b1;
        playStart = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("idle playing", 32'(playing), 32'd0);

        // Single note 3, 100..500, sampled at 200.
        mem[0] = rec(3, 100, 500);
        currentTime = 29'd200;
        startAndWait(0, 8, n);
        checkOutput("first scan latency", 32'(n), 32'd5);
        checkOutput("first scan mask", 32'(activeNotes), 32'h000008);

        // Step time; each change lands before the next scan's snapshot.
        currentTime = 29'd50;
        waitScanDone(8, n);
        checkOutput("t50 mask", 32'(activeNotes), 32'h0);
        checkOutput("t50 playing", 32'(playing), 32'd1);
        currentTime = 29'd300;
        waitScanDone(8, n);
        checkOutput("t300 mask", 32'(activeNotes), 32'h000008);
        currentTime = 29'd600;
        waitScanDone(8, n);
        checkOutput("t600 mask", 32'(activeNotes), 32'h0);
`ifdef LOOP_PLAYBACK_EN
        checkOutput("t600 songEnd loop", 32'(songEnd), 32'd0);
        checkOutput("t600 playing loop", 32'(playing), 32'd1);
`else
        checkOutput("t600 songEnd", 32'(songEnd), 32'd1);
        checkOutput("t600 playing", 32'(playing), 32'd0);
`endif
        applyStimulus(0, 1);
        repeat (2) @(negedge clk);

        // Restart mid-scan with simultaneous start and stop: start wins.
        currentTime = 29'd200;
        applyStimulus(1, 0);
        @(negedge clk);
        startAndWait(1, 8, n);
        checkOutput("restart latency", 32'(n), 32'd5);
        checkOutput("restart mask", 32'(activeNotes), 32'h000008);
        checkOutput("restart playing", 32'(playing), 32'd1);
        applyStimulus(0, 1);
        checkOutput("stop playing", 32'(playing), 32'd0);

        // Open note 23 plus an out-of-range note index.
        clearMem();
        mem[0] = rec(23, 10, 0);
        mem[1] = rec(30, 0, 99);
        currentTime = 29'd20;
        startAndWait(0, 8, n);
        checkOutput("open note mask", 32'(activeNotes), 32'h800000);
        checkOutput("open note songEnd", 32'(songEnd), 32'd0);
        applyStimulus(0, 1);
        @(negedge clk);

        // Full memory, every record active at time 5.
        clearMem();
        for (int i = 0; i < DEPTH; i++) mem[i] = rec(i % NUM_NOTES, 1 + (i % 4), 1000);
        currentTime = 29'd5;
        startAndWait(0, DEPTH + 10, n);
        checkOutput("full scan latency", 32'(n), 32'(DEPTH + 3));
        checkOutput("full scan mask", 32'(activeNotes), 32'hFFFFFF);
        repeat (30) @(negedge clk);
        applyStimulus(0, 1);
        checkOutput("mid-scan stop mask", 32'(activeNotes), 32'h0);
        checkOutput("mid-scan stop playing", 32'(playing), 32'd0);
        repeat (3) @(negedge clk);

        // Finished single note: song end or loop.
        clearMem();
        mem[0] = rec(5, 0, 100);
        currentTime = 29'd150;
        startAndWait(0, 8, n);
        checkOutput("ended note mask", 32'(activeNotes), 32'h0);
`ifdef LOOP_PLAYBACK_EN
        checkOutput("loop timerReset", 32'(timerReset), 32'd1);
        checkOutput("loop playing", 32'(playing), 32'd1);
        checkOutput("loop songEnd", 32'(songEnd), 32'd0);
        waitScanDone(8, n);
        checkOutput("loop period", 32'(n), 32'd4);
        applyStimulus(0, 1);
`else
        checkOutput("end timerReset", 32'(timerReset), 32'd0);
        checkOutput("end songEnd", 32'(songEnd), 32'd1);
        checkOutput("end playing", 32'(playing), 32'd0);
        @(negedge clk);
        checkOutput("end mask cleared", 32'(activeNotes), 32'h0);
`endif

        // Empty memory commits after four cycles.
        clearMem();
        startAndWait(0, 8, n);
        checkOutput("empty latency", 32'(n), 32'd4);
        checkOutput("empty mask", 32'(activeNotes), 32'h0);
        applyStimulus(0, 1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
